// File: rtl/mips_defs.sv
// ---------------------------------------------------------------------------
// mips_defs
// Shared opcode, funct and forwarding-select constants for the pipeline
// control blocks (op_stage_pipe, hazard_unit, controlpath), plus small
// opcode-classification helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_defs;

    // Primary opcodes (MIPS encoding)
    localparam logic [5:0] OP_R      = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // Opcode used for pipeline bubbles; decodes as none of the above
    localparam logic [5:0] BUBBLE_OP = 6'h3F;

    // R-type funct for add
    localparam logic [5:0] FUNCT_ADD = 6'h20;

    // ALU operand forwarding selects
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEM   = 2'b01;
    localparam logic [1:0] FWD_WB    = 2'b10;

    // Result is available at the end of EX, so it can be forwarded from MEM
    function automatic logic is_alu_writer(input logic [5:0] op_in);
        return (op_in == OP_R) || (op_in == OP_ADDI);
    endfunction

    // Instruction writes the register file in WB (loads included)
    function automatic logic is_reg_writer(input logic [5:0] op_in);
        return (op_in == OP_R) || (op_in == OP_ADDI) || (op_in == OP_LW);
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Combinational hazard detection and forwarding select generation.
// Ports:
//   op_ex/rs_ex/rt_ex/dst_ex  EX-stage instruction identity
//   op_mem/dst_mem            MEM-stage opcode and destination
//   op_wb/dst_wb              WB-stage opcode and destination
//   id_rs/id_rt               source registers of the instruction in decode
//   zero                      ALU zero flag of the EX instruction
//   stall                     load-use hazard: hold PC and IF/ID
//   flush                     taken branch: squash IF/ID
//   fwd_a/fwd_b               operand A/B forwarding selects
// ---------------------------------------------------------------------------
module hazard_unit
    import mips_defs::*;
#(
    parameter int OPW = 6,
    parameter int RW  = 5
) (
    input  logic [OPW-1:0] op_ex,
    input  logic [RW-1:0]  rs_ex,
    input  logic [RW-1:0]  rt_ex,
    input  logic [RW-1:0]  dst_ex,
    input  logic [OPW-1:0] op_mem,
    input  logic [RW-1:0]  dst_mem,
    input  logic [OPW-1:0] op_wb,
    input  logic [RW-1:0]  dst_wb,
    input  logic [RW-1:0]  id_rs,
    input  logic [RW-1:0]  id_rt,
    input  logic           zero,
    output logic           stall,
    output logic           flush,
    output logic [1:0]     fwd_a,
    output logic [1:0]     fwd_b
);

    logic taken_s;
    logic load_use_s;
    logic mem_src_s;
    logic wb_src_s;

    // Branch resolution and load-use detection against the decode operands
    always_comb begin
        taken_s    = (op_ex == OP_BEQ) && zero;
        load_use_s = (op_ex == OP_LW) && (dst_ex != {RW{1'b0}}) &&
                     ((dst_ex == id_rs) || (dst_ex == id_rt));
    end

    // A squashed instruction cannot be stalled, so a taken branch masks the stall
    always_comb begin
        flush = taken_s;
        if (taken_s) begin
            stall = 1'b0;
        end else begin
            stall = load_use_s;
        end
    end

    // Qualify MEM/WB as forwarding sources; a load in MEM is excluded because
    // its data is not ready yet (the load-use stall covers that case)
    always_comb begin
        mem_src_s = is_alu_writer(op_mem) && (dst_mem != {RW{1'b0}});
        wb_src_s  = is_reg_writer(op_wb)  && (dst_wb  != {RW{1'b0}});
    end

    // Operand A select, MEM has priority over WB (newer value)
    always_comb begin
        if (mem_src_s && (dst_mem == rs_ex)) begin
            fwd_a = FWD_MEM;
        end else if (wb_src_s && (dst_wb == rs_ex)) begin
            fwd_a = FWD_WB;
        end else begin
            fwd_a = FWD_RF;
        end
    end

    // Operand B select, same priority as operand A
    always_comb begin
        if (mem_src_s && (dst_mem == rt_ex)) begin
            fwd_b = FWD_MEM;
        end else if (wb_src_s && (dst_wb == rt_ex)) begin
            fwd_b = FWD_WB;
        end else begin
            fwd_b = FWD_RF;
        end
    end

endmodule

// File: rtl/op_stage_pipe.sv
// ---------------------------------------------------------------------------
// op_stage_pipe
// Carries decoded instruction identity from decode through EX, MEM and WB,
// inserts bubbles for load-use hazards and taken branches, and produces the
// ALU operand forwarding selects.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_op/id_funct/id_rs/id_rt/id_rd  decode-stage instruction fields
//   zero                        ALU zero flag of the EX instruction
//   op/funct                    EX-stage opcode and funct
//   op_mem, op_wb, dst_wb       MEM/WB opcodes, WB destination
//   stall, flush                hazard controls for fetch/decode
//   fwd_a, fwd_b                operand forwarding selects
// ---------------------------------------------------------------------------
module op_stage_pipe #(
    parameter int             OPW       = 6,
    parameter int             RW        = 5,
    parameter logic [OPW-1:0] BUBBLE_OP = 6'b111111
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] id_op,
    input  logic [OPW-1:0] id_funct,
    input  logic [RW-1:0]  id_rs,
    input  logic [RW-1:0]  id_rt,
    input  logic [RW-1:0]  id_rd,
    input  logic           zero,
    output logic [OPW-1:0] op,
    output logic [OPW-1:0] funct,
    output logic [OPW-1:0] op_mem,
    output logic [OPW-1:0] op_wb,
    output logic [RW-1:0]  dst_wb,
    output logic           stall,
    output logic           flush,
    output logic [1:0]     fwd_a,
    output logic [1:0]     fwd_b
);

    logic [OPW-1:0] op_ex_r;
    logic [OPW-1:0] funct_ex_r;
    logic [RW-1:0]  rs_ex_r;
    logic [RW-1:0]  rt_ex_r;
    logic [RW-1:0]  dst_ex_r;
    logic [OPW-1:0] op_mem_r;
    logic [RW-1:0]  dst_mem_r;
    logic [OPW-1:0] op_wb_r;
    logic [RW-1:0]  dst_wb_r;

    logic [RW-1:0]  id_dst_s;
    logic           stall_s;
    logic           flush_s;

    // Destination register selected in decode; non-writers carry 0
    always_comb begin
        id_dst_s = {RW{1'b0}};
        case (id_op)
            mips_defs::OP_R:    id_dst_s = id_rd;
            mips_defs::OP_ADDI: id_dst_s = id_rt;
            mips_defs::OP_LW:   id_dst_s = id_rt;
            default:            id_dst_s = {RW{1'b0}};
        endcase
    end

    // EX stage register: loads a bubble on stall or taken branch
    always_ff @(posedge clk) begin
        if (rst) begin
            op_ex_r    <= BUBBLE_OP;
            funct_ex_r <= {OPW{1'b0}};
            rs_ex_r    <= {RW{1'b0}};
            rt_ex_r    <= {RW{1'b0}};
            dst_ex_r   <= {RW{1'b0}};
        end else if (stall_s || flush_s) begin
            op_ex_r    <= BUBBLE_OP;
            funct_ex_r <= {OPW{1'b0}};
            rs_ex_r    <= {RW{1'b0}};
            rt_ex_r    <= {RW{1'b0}};
            dst_ex_r   <= {RW{1'b0}};
        end else begin
            op_ex_r    <= id_op;
            funct_ex_r <= id_funct;
            rs_ex_r    <= id_rs;
            rt_ex_r    <= id_rt;
            dst_ex_r   <= id_dst_s;
        end
    end

    // MEM and WB stage registers always advance
    always_ff @(posedge clk) begin
        if (rst) begin
            op_mem_r  <= BUBBLE_OP;
            dst_mem_r <= {RW{1'b0}};
            op_wb_r   <= BUBBLE_OP;
            dst_wb_r  <= {RW{1'b0}};
        end else begin
            op_mem_r  <= op_ex_r;
            dst_mem_r <= dst_ex_r;
            op_wb_r   <= op_mem_r;
            dst_wb_r  <= dst_mem_r;
        end
    end

    hazard_unit #(
        .OPW (OPW),
        .RW  (RW)
    ) u_hazard (
        .op_ex   (op_ex_r),
        .rs_ex   (rs_ex_r),
        .rt_ex   (rt_ex_r),
        .dst_ex  (dst_ex_r),
        .op_mem  (op_mem_r),
        .dst_mem (dst_mem_r),
        .op_wb   (op_wb_r),
        .dst_wb  (dst_wb_r),
        .id_rs   (id_rs),
        .id_rt   (id_rt),
        .zero    (zero),
        .stall   (stall_s),
        .flush   (flush_s),
        .fwd_a   (fwd_a),
        .fwd_b   (fwd_b)
    );

    assign op     = op_ex_r;
    assign funct  = funct_ex_r;
    assign op_mem = op_mem_r;
    assign op_wb  = op_wb_r;
    assign dst_wb = dst_wb_r;
    assign stall  = stall_s;
    assign flush  = flush_s;

endmodule

// File: doc/op_stage_pipe.md
Name: op_stage_pipe

Overview:
- Carries decoded instruction identity (opcode, funct, destination register) from the decode stage through EX, MEM and WB.
- Drives the per-stage opcode buses that controlpath consumes: `op` at EX, `op_mem` at MEM, `op_wb` at WB.
- Detects load-use hazards and taken branches, and inserts bubbles for them.
- Generates forwarding selects for the datapath ALU operand muxes. Sits between the decode/fetch logic and controlpath/datapath.

Parameters:
- OPW, 6, opcode and funct width.
- RW, 5, register index width.
- BUBBLE_OP, 6'b111111, opcode injected for a bubble. It must not decode as R, ADDI, LW, SW, BEQ or J.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_op  in  6  opcode of the instruction in decode
- id_funct  in  6  funct field in decode
- id_rs  in  5  source register rs in decode
- id_rt  in  5  source register rt in decode
- id_rd  in  5  destination register rd in decode
- zero  in  1  ALU zero flag for the instruction currently in EX
- op  out  6  EX-stage opcode
- funct  out  6  EX-stage funct
- op_mem  out  6  MEM-stage opcode
- op_wb  out  6  WB-stage opcode
- dst_wb  out  5  WB-stage destination register
- stall  out  1  hold PC and the IF/ID register this cycle
- flush  out  1  replace the IF/ID contents with a bubble at the next edge
- fwd_a  out  2  operand A select: 00 regfile, 01 MEM result, 10 WB result
- fwd_b  out  2  operand B select, same encoding as fwd_a

Behaviour:
- Stage registers: EX {op, funct, rs, rt, dst}, MEM {op_mem, dst_mem}, WB {op_wb, dst_wb}.
- Timing: one stage per clock. With no hazards, id_op appears on `op` 1 cycle later, on `op_mem` 2 cycles later, on `op_wb` 3 cycles later.
- Reset (synchronous, rst=1 at an edge):
  - all stage opcodes become BUBBLE_OP; funct, rs, rt and all dst fields become 0.
  - This guarantees no w_reg/w_data/r_data is asserted after reset, because controlpath treats op 0 as R-type.
  - A reset mid-operation discards every in-flight instruction.
- Destination computed in decode:
  - R-type: id_rd.
  - ADDI or LW: id_rt.
  - anything else: 0.
  - Register 0 is never a hazard or forwarding source.
- Load-use stall, combinational:
  - stall = (op==LW) && dst_ex!=0 && (dst_ex==id_rs || dst_ex==id_rt).
  - On a stall edge: EX loads a bubble, the decode instruction is held upstream, MEM/WB advance normally.
  - Exactly 1 bubble per load-use pair.
- Branch, combinational:
  - taken = (op==BEQ) && zero. flush = taken.
  - On a taken edge, EX loads a bubble instead of the decode instruction.
  - Total penalty: 2 bubbles (the ID instruction and the IF instruction).
- Jump: J decoded in decode, passes down the pipe as a non-writing op. No flush is generated by this block.
- Simultaneous taken and stall: flush wins and stall is forced to 0, because the stalled instruction is being squashed anyway.
- Forwarding, combinational, evaluated per EX operand (rs for A, rt for B):
  - 01 if op_mem is a register writer (R/ADDI), dst_mem!=0 and dst_mem matches the operand.
  - else 10 if op_wb is a writer (R/ADDI/LW), dst_wb!=0 and dst_wb matches.
  - else 00.
  - MEM takes priority over WB.
  - LW in MEM never forwards; this case is covered by the stall.
- Bubbles carry dst=0 and never trigger hazards.

Decomposition:
- Shared package `mips_defs`:
  - opcode constants OP_R, OP_J, OP_ADDI, OP_BEQ, OP_LW, OP_SW, BUBBLE_OP, FUNCT_ADD;
  - forwarding select constants FWD_RF, FWD_MEM, FWD_WB.
- controlpath is migrated to import the same package.
- One sub-module: `hazard_unit`, which is combinational and produces stall, flush, fwd_a and fwd_b from the stage registers.

Test Plan:
- Reset → op, op_mem and op_wb all read 6'h3F; stall=0, flush=0, fwd_a=fwd_b=00.
- ADDI r1 then R-type using rs=1, no gap → in the 2nd instruction's EX cycle fwd_a=01; one cycle later a dependent 3rd instruction sees fwd_a=10.
- LW r2 followed immediately by R-type using rt=2 → stall=1 for exactly 1 cycle; `op` shows 6'h3F the next cycle; the dependent instruction then gets fwd_b=10.
- BEQ reaching EX with zero=1 → flush=1 for 1 cycle; the next-cycle `op`=6'h3F; the instruction after the branch never reaches op_wb.
- BEQ with zero=1 while LW-use is present in decode → flush=1 and stall=0.
- Assert rst for 1 cycle mid-stream with an LW in MEM → next cycle op_mem=op_wb=6'h3F and the write-enable outputs of controlpath are all 0.
